// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(4x4,3x3) tile scheduler.
package winograd_pkg;

    localparam int unsigned TILE_IN  = 6;
    localparam int unsigned KERNEL   = 3;
    localparam int unsigned TILE_OUT = TILE_IN - KERNEL + 1;
    localparam int unsigned IMG_ROWS = 10;
    localparam int unsigned IMG_COLS = 12;
    localparam int unsigned MASK_W   = TILE_OUT * TILE_OUT;
    localparam int unsigned IDX_W    = 2;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } tile_idx_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;

    // Plain row-major step, column fastest; the caller decides when the grid is exhausted.
    function automatic tile_idx_t tile_step(input tile_idx_t t, input logic [IDX_W-1:0] last_col);
        tile_idx_t n;
        if (t.col == last_col) begin
            n.row = t.row + 2'd1;
            n.col = 2'd0;
        end else begin
            n.row = t.row;
            n.col = t.col + 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/winograd_tile_scheduler_if.sv
// Tile issue, result retire and output-buffer write signals between scheduler and engine.
interface winograd_tile_scheduler_if;
    import winograd_pkg::*;

    logic                  tile_valid;
    logic                  tile_ready;
    logic [IDX_W-1:0]      tile_row;
    logic [IDX_W-1:0]      tile_col;
    logic                  res_valid;
    logic                  res_ready;
    logic                  wr_en;
    logic [3:0]            wr_row_base;
    logic [3:0]            wr_col_base;
    logic [MASK_W-1:0]     wr_mask;

    modport master (
        output tile_valid, tile_row, tile_col, res_ready,
        output wr_en, wr_row_base, wr_col_base, wr_mask,
        input  tile_ready, res_valid
    );

    modport slave (
        input  tile_valid, tile_row, tile_col, res_ready,
        input  wr_en, wr_row_base, wr_col_base, wr_mask,
        output tile_ready, res_valid
    );
endinterface

// File: rtl/winograd_crop_mask.sv
// Per-element write mask of a 4x4 result tile, cropped to the valid convolution window.
module winograd_crop_mask
    import winograd_pkg::*;
#(
    parameter int unsigned OUT_ROWS = IMG_ROWS - KERNEL + 1,
    parameter int unsigned OUT_COLS = IMG_COLS - KERNEL + 1
) (
    input  tile_idx_t          tile,
    output logic [MASK_W-1:0]  mask,
    output logic               empty
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < TILE_OUT; i++) begin
            for (int unsigned j = 0; j < TILE_OUT; j++) begin
                mask[4'(TILE_OUT * i + j)] = ((TILE_OUT * 32'(tile.row) + i) < OUT_ROWS) &&
                                             ((TILE_OUT * 32'(tile.col) + j) < OUT_COLS);
            end
        end
        empty = ~|mask;
    end

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Issues 6x6 input tiles to the Winograd engine and retires 4x4 results in order.
// Optional WINOGRAD_SKIP_EMPTY_TILES_EN: never issue tiles whose crop mask is all zero.
module winograd_tile_scheduler
    import winograd_pkg::*;
#(
    parameter int unsigned TILES_R         = 3,
    parameter int unsigned TILES_C         = 3,
    parameter int unsigned OUT_ROWS        = IMG_ROWS - KERNEL + 1,
    parameter int unsigned OUT_COLS        = IMG_COLS - KERNEL + 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    winograd_tile_scheduler_if.master bus
);

    localparam int unsigned      CNT_W    = 3;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(TILES_R - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(TILES_C - 1);

    sched_state_e      state;
    tile_idx_t         iss;
    tile_idx_t         ret;
    logic              all_issued;
    logic [CNT_W-1:0]  outst;
    logic              tile_valid_q;
    logic              res_ready_q;
    logic              wr_en_q;
    logic [3:0]        wr_row_base_q;
    logic [3:0]        wr_col_base_q;
    logic [MASK_W-1:0] wr_mask_q;

    logic [MASK_W-1:0] ret_mask;
    logic              ret_empty;
    tile_idx_t         iss_a_c, ret_a_c, iss_nxt_c, ret_nxt_c;
    logic              iss_last_c, iss_end_c;
    logic              hs_issue_c, hs_ret_c, ret_ok_c, all_issued_c;
    logic [CNT_W-1:0]  outst_c;

    winograd_crop_mask #(.OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)) u_ret_mask (
        .tile(ret), .mask(ret_mask), .empty(ret_empty)
    );

    assign iss_a_c    = tile_step(iss, LAST_COL);
    assign ret_a_c    = tile_step(ret, LAST_COL);
    assign iss_last_c = (iss.row == LAST_ROW) && (iss.col == LAST_COL);

`ifdef WINOGRAD_SKIP_EMPTY_TILES_EN
    // Emptiness is monotonic in row and column: an empty column jumps to the next row,
    // an empty first column means every remaining row is empty too.
    tile_idx_t         iss_b_c, ret_b_c;
    logic              iss_a_empty, iss_b_empty, ret_a_empty, ret_b_empty;
    logic [MASK_W-1:0] iss_a_mask_unused, iss_b_mask_unused, ret_a_mask_unused, ret_b_mask_unused;

    assign iss_b_c = '{row: iss_a_c.row + 2'd1, col: 2'd0};
    assign ret_b_c = '{row: ret_a_c.row + 2'd1, col: 2'd0};

    winograd_crop_mask #(.OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)) u_iss_a (
        .tile(iss_a_c), .mask(iss_a_mask_unused), .empty(iss_a_empty));
    winograd_crop_mask #(.OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)) u_iss_b (
        .tile(iss_b_c), .mask(iss_b_mask_unused), .empty(iss_b_empty));
    winograd_crop_mask #(.OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)) u_ret_a (
        .tile(ret_a_c), .mask(ret_a_mask_unused), .empty(ret_a_empty));
    winograd_crop_mask #(.OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)) u_ret_b (
        .tile(ret_b_c), .mask(ret_b_mask_unused), .empty(ret_b_empty));

    assign iss_nxt_c = iss_a_empty ? iss_b_c : iss_a_c;
    assign ret_nxt_c = ret_a_empty ? ret_b_c : ret_a_c;
    assign iss_end_c = iss_last_c ||
                       (iss_a_empty && ((iss_a_c.col == 2'd0) || (iss_a_c.row == LAST_ROW) || iss_b_empty));
`else
    assign iss_nxt_c = iss_a_c;
    assign ret_nxt_c = ret_a_c;
    assign iss_end_c = iss_last_c;
`endif

    assign hs_issue_c   = tile_valid_q && bus.tile_ready;
    assign hs_ret_c     = bus.res_valid && res_ready_q;
    assign ret_ok_c     = hs_ret_c && (outst != '0);
    assign outst_c      = outst + CNT_W'(hs_issue_c) - CNT_W'(ret_ok_c);
    assign all_issued_c = all_issued || (hs_issue_c && iss_end_c);

    assign bus.tile_valid  = tile_valid_q;
    assign bus.tile_row    = iss.row;
    assign bus.tile_col    = iss.col;
    assign bus.res_ready   = res_ready_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_row_base = wr_row_base_q;
    assign bus.wr_col_base = wr_col_base_q;
    assign bus.wr_mask     = wr_mask_q;

    // Frame FSM with issue/retire bookkeeping; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            iss           <= '0;
            ret           <= '0;
            all_issued    <= 1'b0;
            outst         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            tile_valid_q  <= 1'b0;
            res_ready_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_row_base_q <= '0;
            wr_col_base_q <= '0;
            wr_mask_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        iss          <= '0;
                        ret          <= '0;
                        all_issued   <= 1'b0;
                        outst        <= '0;
                        tile_valid_q <= 1'b1;
                        res_ready_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs_issue_c && !iss_end_c) iss <= iss_nxt_c;
                    if (hs_ret_c && (outst == '0)) err <= 1'b1;
                    if (ret_ok_c) begin
                        wr_en_q       <= !ret_empty;
                        wr_row_base_q <= 4'(TILE_OUT * ret.row);
                        wr_col_base_q <= 4'(TILE_OUT * ret.col);
                        wr_mask_q     <= ret_mask;
                        ret           <= ret_nxt_c;
                    end
                    all_issued   <= all_issued_c;
                    outst        <= outst_c;
                    tile_valid_q <= !all_issued_c && (outst_c < CNT_W'(MAX_OUTSTANDING));
                    if (all_issued_c && (outst_c == '0)) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        tile_valid_q <= 1'b0;
                        res_ready_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
